// File: rtl/gol_ctrl_pkg.sv
// Shared register map, control/status bit positions and FSM encoding
// for the Game-of-Life step controller.
package gol_ctrl_pkg;

    localparam logic [2:0] RegCtrl    = 3'd0;
    localparam logic [2:0] RegPeriod  = 3'd1;
    localparam logic [2:0] RegGen     = 3'd2;
    localparam logic [2:0] RegStatus  = 3'd3;
    localparam logic [2:0] RegRowSel  = 3'd4;
    localparam logic [2:0] RegRowData = 3'd5;

    localparam int unsigned CtrlRun    = 0;
    localparam int unsigned CtrlStep   = 1;
    localparam int unsigned CtrlIrqEn  = 2;
    localparam int unsigned CtrlClrGen = 3;

    localparam int unsigned StatBusy    = 0;
    localparam int unsigned StatIrqPend = 1;
    localparam int unsigned StatLoadErr = 2;

    typedef enum logic [1:0] {
        StIdle,
        StWaitTick,
        StStep,
        StWaitDone
    } gol_state_t;

    // Expands Wishbone byte enables into a 32-bit bit mask.
    function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{sel[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/gol_tick_prescaler.sv
// Loadable down-counter that times the free-running step period.
module gol_tick_prescaler #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gol_step_controller.sv
// Wishbone slave that loads/reads Game-of-Life rows and sequences single or
// free-running generation steps, counting generations and raising an IRQ.
module gol_step_controller
    import gol_ctrl_pkg::*;
#(
    parameter logic [31:0]        BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned        ROWS       = 8,
    parameter int unsigned        COLS       = 8,
    parameter int unsigned        PRESC_W    = 16,
    parameter logic [PRESC_W-1:0] PERIOD_RST = PRESC_W'(999),
    localparam int unsigned       ROW_W      = $clog2(ROWS)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             arr_step_o,
    input  logic             arr_done_i,
    output logic             arr_load_o,
    output logic [ROW_W-1:0] arr_row_o,
    output logic [COLS-1:0]  arr_row_data_o,
    input  logic [COLS-1:0]  arr_row_data_i,
    output logic             irq_o
);

    gol_state_t state_q, state_d;

    logic               ack_q;
    logic [31:0]        dat_q, dat_d;
    logic               run_q, run_d;
    logic               irq_en_q, irq_en_d;
    logic [PRESC_W-1:0] period_q, period_d;
    logic [31:0]        gen_q, gen_d;
    logic               irq_pend_q, irq_pend_d;
    logic               load_err_q, load_err_d;
    logic [ROW_W-1:0]   row_sel_q, row_sel_d;
    logic [COLS-1:0]    row_data_q, row_data_d;
    logic               load_q, load_d;
    logic               step_req_q, step_req_d;

    logic        win_hit, req, wr, rd, busy, done_evt;
    logic        clr_gen, w1c_pend, w1c_err, err_set;
    logic        presc_load, presc_en, presc_zero;
    logic [2:0]  off;
    logic [31:0] wmask, wdat_sel, period_m, row_sel_m, row_data_m, rdata;

    assign win_hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req      = wbs_cyc_i & wbs_stb_i & ~ack_q & win_hit;
    assign wr       = req & wbs_we_i;
    assign rd       = req & ~wbs_we_i;
    assign off      = wbs_adr_i[4:2];
    assign busy     = (state_q == StStep) || (state_q == StWaitDone);
    assign done_evt = (state_q == StWaitDone) && arr_done_i;

    assign wmask      = sel_to_mask(wbs_sel_i);
    assign wdat_sel   = wbs_dat_i & wmask;
    assign period_m   = (32'(period_q) & ~wmask) | wdat_sel;
    assign row_sel_m  = (32'(row_sel_q) & ~wmask) | wdat_sel;
    assign row_data_m = (32'(row_data_q) & ~wmask) | wdat_sel;

    logic unused_bits;
    assign unused_bits = ^{wbs_adr_i[7:5], wbs_adr_i[1:0], period_m, row_sel_m,
                           row_data_m, wdat_sel};

    always_comb begin
        run_d      = run_q;
        irq_en_d   = irq_en_q;
        period_d   = period_q;
        row_sel_d  = row_sel_q;
        row_data_d = row_data_q;
        gen_d      = gen_q;
        irq_pend_d = irq_pend_q;
        load_err_d = load_err_q;
        step_req_d = 1'b0;
        load_d     = 1'b0;
        clr_gen    = 1'b0;
        w1c_pend   = 1'b0;
        w1c_err    = 1'b0;
        err_set    = 1'b0;
        if (wr) begin
            case (off)
                RegCtrl: begin
                    if (wbs_sel_i[0]) begin
                        run_d    = wbs_dat_i[CtrlRun];
                        irq_en_d = wbs_dat_i[CtrlIrqEn];
                    end
                    step_req_d = wdat_sel[CtrlStep];
                    clr_gen    = wdat_sel[CtrlClrGen];
                end
                RegPeriod: period_d = period_m[PRESC_W-1:0];
                RegStatus: begin
                    w1c_pend = wdat_sel[StatIrqPend];
                    w1c_err  = wdat_sel[StatLoadErr];
                end
                RegRowSel: row_sel_d = row_sel_m[ROW_W-1:0];
                RegRowData: begin
                    if (busy) begin
                        err_set = 1'b1;
                    end else begin
                        row_data_d = row_data_m[COLS-1:0];
                        load_d     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Clear beats a coincident increment; a set beats a coincident W1C.
        if (done_evt) gen_d = gen_q + 32'd1;
        if (clr_gen)  gen_d = '0;
        if (w1c_pend) irq_pend_d = 1'b0;
        if (done_evt) irq_pend_d = 1'b1;
        if (w1c_err)  load_err_d = 1'b0;
        if (err_set)  load_err_d = 1'b1;
    end

    always_comb begin
        rdata = '0;
        case (off)
            RegCtrl: begin
                rdata[CtrlRun]   = run_q;
                rdata[CtrlIrqEn] = irq_en_q;
            end
            RegPeriod: rdata[PRESC_W-1:0] = period_q;
            RegGen:    rdata = gen_q;
            RegStatus: begin
                rdata[StatBusy]    = busy;
                rdata[StatIrqPend] = irq_pend_q;
                rdata[StatLoadErr] = load_err_q;
            end
            RegRowSel:  rdata[ROW_W-1:0] = row_sel_q;
            RegRowData: rdata[COLS-1:0]  = arr_row_data_i;
            default:    rdata = '0;
        endcase
        dat_d = rd ? rdata : '0;
    end

    always_comb begin
        state_d    = state_q;
        presc_load = 1'b0;
        presc_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step_req_q) begin
                    state_d = StStep;
                end else if (run_q) begin
                    state_d    = StWaitTick;
                    presc_load = 1'b1;
                end
            end
            StWaitTick: begin
                if (step_req_q) begin
                    state_d = StStep;
                end else if (!run_q) begin
                    state_d = StIdle;
                end else if (presc_zero) begin
                    state_d = StStep;
                end else begin
                    presc_en = 1'b1;
                end
            end
            StStep: state_d = StWaitDone;
            StWaitDone: begin
                if (arr_done_i) begin
                    if (run_q) begin
                        state_d    = StWaitTick;
                        presc_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    gol_tick_prescaler #(
        .Width(PRESC_W)
    ) u_prescaler (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .load_i    (presc_load),
        .load_val_i(period_q),
        .en_i      (presc_en),
        .zero_o    (presc_zero)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= PERIOD_RST;
            gen_q      <= '0;
            irq_pend_q <= 1'b0;
            load_err_q <= 1'b0;
            row_sel_q  <= '0;
            row_data_q <= '0;
            load_q     <= 1'b0;
            step_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= req;
            dat_q      <= dat_d;
            run_q      <= run_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            gen_q      <= gen_d;
            irq_pend_q <= irq_pend_d;
            load_err_q <= load_err_d;
            row_sel_q  <= row_sel_d;
            row_data_q <= row_data_d;
            load_q     <= load_d;
            step_req_q <= step_req_d;
        end
    end

    assign wbs_ack_o      = ack_q;
    assign wbs_dat_o      = dat_q;
    assign arr_step_o     = (state_q == StStep);
    assign arr_load_o     = load_q;
    assign arr_row_o      = row_sel_q;
    assign arr_row_data_o = row_data_q;
    assign irq_o          = irq_pend_q & irq_en_q;

endmodule

// File: tb/tb_gol_step_controller.sv
// Self-checking bench for gol_step_controller with a behavioural cell-array
// model (row memory plus programmable step-to-done latency).
module tb_gol_step_controller;

    localparam logic [31:0] BASE      = 32'h3000_0000;
    localparam logic [31:0] A_CTRL    = BASE + 32'h00;
    localparam logic [31:0] A_PERIOD  = BASE + 32'h04;
    localparam logic [31:0] A_GEN     = BASE + 32'h08;
    localparam logic [31:0] A_STATUS  = BASE + 32'h0C;
    localparam logic [31:0] A_ROWSEL  = BASE + 32'h10;
    localparam logic [31:0] A_ROWDATA = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o, arr_step_o, arr_done_i, arr_load_o, irq_o;
    logic [2:0]  arr_row_o;
    logic [7:0]  arr_row_data_o, arr_row_data_i;

    logic [7:0] arr_mem [8];
    logic [7:0] exp_rows [8];
    int         n_checks = 0, n_fail = 0;
    int         cyc_cnt = 0, step_cnt = 0, load_cnt = 0;
    int         stamps [256];
    int         lat = 1, pend = 0;
    logic       done_auto = 1'b0, done_force = 1'b0;
    logic [2:0] last_row = '0;
    logic [7:0] last_data = '0;
    int         ack_cyc = 0, exp_gen = 0;
    logic [31:0] cur_period = 32'd999;

    gol_step_controller dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (wbs_cyc_i),
        .wbs_stb_i     (wbs_stb_i),
        .wbs_we_i      (wbs_we_i),
        .wbs_sel_i     (wbs_sel_i),
        .wbs_adr_i     (wbs_adr_i),
        .wbs_dat_i     (wbs_dat_i),
        .wbs_dat_o     (wbs_dat_o),
        .wbs_ack_o     (wbs_ack_o),
        .arr_step_o    (arr_step_o),
        .arr_done_i    (arr_done_i),
        .arr_load_o    (arr_load_o),
        .arr_row_o     (arr_row_o),
        .arr_row_data_o(arr_row_data_o),
        .arr_row_data_i(arr_row_data_i),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;

    // Cell-array model: row store, step-to-done latency (lat==0: never done).
    assign arr_row_data_i = arr_mem[arr_row_o];
    assign arr_done_i     = done_auto | done_force;

    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (arr_step_o) begin
            stamps[step_cnt % 256] <= cyc_cnt;
            step_cnt <= step_cnt + 1;
        end
        if (arr_load_o) begin
            arr_mem[arr_row_o] <= arr_row_data_o;
            load_cnt  <= load_cnt + 1;
            last_row  <= arr_row_o;
            last_data <= arr_row_data_o;
        end
        if (rst) begin
            pend      <= 0;
            done_auto <= 1'b0;
        end else begin
            done_auto <= (pend == 1);
            if (arr_step_o) pend <= lat;
            else if (pend > 0) pend <= pend - 1;
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        acked = 1'b0;
        rdat  = '0;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin
                acked   = 1'b1;
                rdat    = wbs_dat_o;
                ack_cyc = cyc_cnt;
                break;
            end
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d);
        logic [31:0] r;
        logic        a;
        wb_xfer(adr, 1'b1, d, 4'hF, r, a);
        n_checks++;
        if (!a) begin
            n_fail++;
            $display("FAIL wb_write_ack adr=%h acked=%0d required=1", adr, a);
        end
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] d);
        logic a;
        wb_xfer(adr, 1'b0, 32'h0, 4'hF, d, a);
        n_checks++;
        if (!a) begin
            n_fail++;
            $display("FAIL wb_read_ack adr=%h acked=%0d required=1", adr, a);
        end
    endtask

    // Write whose request-sampling edge coincides with a forced done pulse.
    task automatic wb_wr_done(input logic [31:0] adr, input logic [31:0] d);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = adr;  wbs_dat_i = d;    wbs_sel_i = 4'hF;
        done_force = 1'b1;
        @(posedge clk); #1;
        done_force = 1'b0;
        n_checks++;
        if (wbs_ack_o !== 1'b1) begin
            n_fail++;
            $display("FAIL coincident_write_ack got=%b required=1", wbs_ack_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wait_steps(input int target, input int budget);
        for (int i = 0; i < budget && step_cnt < target; i++) begin
            @(negedge clk); #1;
        end
        n_checks++;
        if (step_cnt < target) begin
            n_fail++;
            $display("FAIL step_timeout steps=%0d required=%0d", step_cnt, target);
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({irq_o, arr_step_o, arr_load_o, wbs_ack_o, wbs_dat_o, arr_row_o, arr_row_data_o}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs irq=%b step=%b load=%b ack=%b dat=%h row=%0d rd=%h",
                     irq_o, arr_step_o, arr_load_o, wbs_ack_o, wbs_dat_o, arr_row_o,
                     arr_row_data_o);
        end
        rst = 1'b0;
        wb_rd(A_CTRL, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=0", r); end
        wb_rd(A_PERIOD, r);
        n_checks++;
        if (r !== 32'd999) begin n_fail++; $display("FAIL reset_period got=%0d exp=999", r); end
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_gen got=%h exp=0", r); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=0", r); end
        wb_rd(A_ROWSEL, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_rowsel got=%h exp=0", r); end
    endtask

    task automatic test_row_load();
        logic [31:0] r;
        int          row, l0;
        logic [7:0]  data;
        for (int k = 0; k < 6; k++) begin
            row  = (k == 0) ? 3 : int'($urandom_range(0, 15));
            data = (k == 0) ? 8'h5A : 8'($urandom);
            wb_wr(A_ROWSEL, 32'(row));
            l0 = load_cnt;
            wb_wr(A_ROWDATA, {24'h0, data});
            @(negedge clk); #1;
            exp_rows[row % 8] = data;
            n_checks++;
            if (load_cnt != l0 + 1 || last_row != 3'(row % 8) || last_data != data) begin
                n_fail++;
                $display("FAIL row_load pulses=%0d row=%0d data=%h exp pulses=%0d row=%0d data=%h",
                         load_cnt - l0, last_row, last_data, 1, row % 8, data);
            end
            wb_rd(A_ROWSEL, r);
            n_checks++;
            if (r !== 32'(row % 8)) begin
                n_fail++;
                $display("FAIL rowsel_wrap got=%0d exp=%0d", r, row % 8);
            end
            wb_rd(A_ROWDATA, r);
            n_checks++;
            if (r !== {24'h0, exp_rows[row % 8]} || load_cnt != l0 + 1) begin
                n_fail++;
                $display("FAIL row_readback got=%h exp=%h pulses=%0d", r, exp_rows[row % 8],
                         load_cnt - l0);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] r;
        logic        a;
        wb_xfer(A_PERIOD, 1'b1, 32'h0000_ABCD, 4'b0010, r, a);
        wb_rd(A_PERIOD, r);
        n_checks++;
        if (r !== 32'h0000_ABE7) begin
            n_fail++;
            $display("FAIL byte_enable_hi got=%h exp=0000abe7", r);
        end
        wb_xfer(A_PERIOD, 1'b1, 32'hFFFF_FF12, 4'b0001, r, a);
        wb_rd(A_PERIOD, r);
        cur_period = 32'h0000_AB12;
        n_checks++;
        if (r !== cur_period) begin
            n_fail++;
            $display("FAIL byte_enable_lo got=%h exp=%h", r, cur_period);
        end
    endtask

    task automatic test_single_step();
        logic [31:0] r;
        int          s0;
        lat = 4;
        s0  = step_cnt;
        wb_wr(A_CTRL, 32'h6);
        wait_steps(s0 + 1, 20);
        n_checks++;
        if (stamps[s0 % 256] != ack_cyc + 1) begin
            n_fail++;
            $display("FAIL step_latency got=%0d exp=%0d", stamps[s0 % 256] - ack_cyc, 1);
        end
        repeat (10) @(negedge clk);
        exp_gen = exp_gen + 1;
        n_checks++;
        if (step_cnt != s0 + 1 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL single_step steps=%0d irq=%b exp steps=1 irq=1", step_cnt - s0, irq_o);
        end
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'(exp_gen)) begin n_fail++; $display("FAIL gen_after_step got=%0d exp=%0d", r, exp_gen); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h2) begin n_fail++; $display("FAIL status_pend got=%h exp=2", r); end
        wb_rd(A_CTRL, r);
        n_checks++;
        if (r !== 32'h4) begin n_fail++; $display("FAIL ctrl_step_reads0 got=%h exp=4", r); end
        wb_wr(A_STATUS, 32'h2);
        @(negedge clk);
        n_checks++;
        if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_w1c got=%b exp=0", irq_o); end
    endtask

    task automatic test_free_run();
        logic [31:0] r;
        int          s0, sc, per;
        for (int it = 0; it < 3; it++) begin
            per = (it == 0) ? 2 : int'($urandom_range(0, 6));
            lat = (it == 0) ? 1 : int'($urandom_range(1, 3));
            wb_wr(A_PERIOD, 32'(per));
            cur_period = 32'(per);
            s0 = step_cnt;
            wb_wr(A_CTRL, 32'h1);
            wait_steps(s0 + 4, 200);
            n_checks++;
            if (stamps[s0 % 256] != ack_cyc + per + 2) begin
                n_fail++;
                $display("FAIL run_first_step got=%0d exp=%0d", stamps[s0 % 256] - ack_cyc,
                         per + 2);
            end
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (stamps[(s0 + k + 1) % 256] - stamps[(s0 + k) % 256] != per + 2 + lat) begin
                    n_fail++;
                    $display("FAIL run_period period=%0d lat=%0d got=%0d exp=%0d", per, lat,
                             stamps[(s0 + k + 1) % 256] - stamps[(s0 + k) % 256], per + 2 + lat);
                end
            end
            lat = 8;
            sc  = step_cnt;
            wait_steps(sc + 1, 40);
            wb_wr(A_CTRL, 32'h0);
            sc = step_cnt;
            repeat (60) @(negedge clk);
            exp_gen = exp_gen + (sc - s0);
            n_checks++;
            if (step_cnt != sc) begin
                n_fail++;
                $display("FAIL run_stop extra_steps=%0d exp=0", step_cnt - sc);
            end
            wb_rd(A_GEN, r);
            n_checks++;
            if (r !== 32'(exp_gen)) begin n_fail++; $display("FAIL run_gen got=%0d exp=%0d", r, exp_gen); end
            wb_rd(A_STATUS, r);
            n_checks++;
            if (r[0] !== 1'b0) begin n_fail++; $display("FAIL run_idle busy=%b exp=0", r[0]); end
        end
    endtask

    task automatic test_load_err_and_races();
        logic [31:0] r;
        int          s0, l0;
        lat = 0;
        wb_wr(A_STATUS, 32'h6);
        s0 = step_cnt;
        wb_wr(A_CTRL, 32'h6);
        wait_steps(s0 + 1, 20);
        l0 = load_cnt;
        wb_wr(A_ROWDATA, 32'hFF);
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_cnt != l0) begin n_fail++; $display("FAIL busy_load pulses=%0d exp=0", load_cnt - l0); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h5) begin n_fail++; $display("FAIL load_err_status got=%h exp=5", r); end
        wb_wr(A_CTRL, 32'h6);
        repeat (5) @(negedge clk);
        n_checks++;
        if (step_cnt != s0 + 1) begin
            n_fail++;
            $display("FAIL step_in_wait_done steps=%0d exp=1", step_cnt - s0);
        end
        wb_wr_done(A_CTRL, 32'hC);
        exp_gen = 0;
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'(exp_gen)) begin n_fail++; $display("FAIL clr_gen_wins got=%0d exp=0", r); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h6) begin n_fail++; $display("FAIL status_after_clr got=%h exp=6", r); end
        wb_wr(A_STATUS, 32'h2);
        s0 = step_cnt;
        wb_wr(A_CTRL, 32'h6);
        wait_steps(s0 + 1, 20);
        wb_wr_done(A_STATUS, 32'h2);
        exp_gen = exp_gen + 1;
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h6 || irq_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set_wins status=%h irq=%b exp status=6 irq=1", r, irq_o);
        end
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'(exp_gen)) begin n_fail++; $display("FAIL gen_after_race got=%0d exp=%0d", r, exp_gen); end
        wb_wr(A_STATUS, 32'h6);
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL status_w1c got=%h exp=0", r); end
    endtask

    task automatic test_stray_done();
        logic [31:0] r;
        @(negedge clk); done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'(exp_gen)) begin n_fail++; $display("FAIL stray_done_gen got=%0d exp=%0d", r, exp_gen); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL stray_done_status got=%h exp=0", r); end
    endtask

    task automatic test_window();
        logic [31:0] r;
        logic        a;
        wb_xfer(BASE + 32'h1C, 1'b0, 32'h0, 4'hF, r, a);
        n_checks++;
        if (a !== 1'b1 || r !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read acked=%b data=%h exp acked=1 data=0", a, r);
        end
        wb_xfer(BASE + 32'h18, 1'b1, 32'hFFFF_FFFF, 4'hF, r, a);
        n_checks++;
        if (a !== 1'b1) begin n_fail++; $display("FAIL reserved_write acked=%b exp=1", a); end
        wb_xfer(BASE + 32'h104, 1'b1, 32'h55, 4'hF, r, a);
        n_checks++;
        if (a !== 1'b0) begin n_fail++; $display("FAIL out_of_window acked=%b exp=0", a); end
        wb_rd(A_PERIOD, r);
        n_checks++;
        if (r !== cur_period) begin n_fail++; $display("FAIL window_period got=%h exp=%h", r, cur_period); end
    endtask

    task automatic test_reset_mid_step();
        logic [31:0] r;
        int          s0;
        lat = 0;
        s0  = step_cnt;
        wb_wr(A_CTRL, 32'h6);
        wait_steps(s0 + 1, 20);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        repeat (3) @(negedge clk);
        exp_gen    = 0;
        cur_period = 32'd999;
        n_checks++;
        if (step_cnt != s0 + 1 || irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_step steps=%0d irq=%b exp steps=1 irq=0", step_cnt - s0, irq_o);
        end
        wb_rd(A_GEN, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mid_gen got=%0d exp=0", r); end
        wb_rd(A_STATUS, r);
        n_checks++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_mid_status got=%h exp=0", r); end
        wb_rd(A_PERIOD, r);
        n_checks++;
        if (r !== cur_period) begin n_fail++; $display("FAIL reset_mid_period got=%0d exp=999", r); end
    endtask

    initial begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0;   wbs_dat_i = '0;
        rst = 1'b1;
        test_reset();
        test_row_load();
        test_byte_enable();
        test_single_step();
        test_free_run();
        test_load_err_and_races();
        test_stray_done();
        test_window();
        test_reset_mid_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
